dmem_arbiter: RTL

//  Shares the single-port byte-addressed data memory between the core load/store unit (port C) and a
//  DMA/debug master (port D). Grants at most one request per cycle, checks alignment and range,

---
 rtl/dmem_arbiter_pkg.sv | 37 +++
 rtl/dmem_access_check.sv | 28 ++
 rtl/dmem_arbiter.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/dmem_arbiter_pkg.sv
// Shared data-memory access encodings, request bundle and helpers for the dmem arbiter.
// Mode values match the load/store unit funct3 encoding; stores reuse the B/H/W codes.
package dmem_arbiter_pkg;

  localparam logic [2:0] DM_LB  = 3'b000;
  localparam logic [2:0] DM_LH  = 3'b001;
  localparam logic [2:0] DM_LW  = 3'b010;
  localparam logic [2:0] DM_LBU = 3'b100;
  localparam logic [2:0] DM_LHU = 3'b101;

  localparam logic [2:0] DM_SIZE_B = 3'd1;
  localparam logic [2:0] DM_SIZE_H = 3'd2;
  localparam logic [2:0] DM_SIZE_W = 3'd4;

  typedef enum logic [1:0] {
    GntNone,
    GntC,
    GntD
  } grant_e;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        we;
    logic [2:0]  mode;
  } dm_req_t;

  // Unknown modes are treated as word accesses.
  function automatic logic [2:0] dm_size(input logic [2:0] mode);
    case (mode)
      DM_LB, DM_LBU: return DM_SIZE_B;
      DM_LH, DM_LHU: return DM_SIZE_H;
      default:       return DM_SIZE_W;
    endcase
  endfunction

endpackage

// File: rtl/dmem_access_check.sv
// Combinational alignment and range check for one data-memory request.
module dmem_access_check
  import dmem_arbiter_pkg::*;
#(
  parameter int unsigned MemBytes = 1024
) (
  input  logic [31:0] addr_i,
  input  logic [2:0]  mode_i,
  output logic        legal_o
);

  logic [2:0]  size;
  logic        misaligned;
  logic [32:0] end_addr;

  always_comb begin
    size = dm_size(mode_i);
    // 33-bit sum so addresses near 2^32 cannot wrap back into range.
    end_addr = {1'b0, addr_i} + {30'd0, size};
    case (size)
      DM_SIZE_H: misaligned = addr_i[0];
      DM_SIZE_W: misaligned = |addr_i[1:0];
      default:   misaligned = 1'b0;
    endcase
    legal_o = !misaligned && (end_addr <= 33'(MemBytes));
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Arbitrates the single-port data memory between the core (C) and DMA/debug (D) ports,
// with core priority, a starvation guard for D and a registered one-cycle response.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int unsigned MEM_BYTES    = 1024,
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned CNT_W        = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        c_valid,
  output logic        c_ready,
  input  logic [31:0] c_addr,
  input  logic [31:0] c_wdata,
  input  logic        c_we,
  input  logic [2:0]  c_mode,
  output logic        c_rsp_valid,
  output logic [31:0] c_rsp_rdata,
  output logic        c_rsp_err,
  input  logic        d_valid,
  output logic        d_ready,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic        d_we,
  input  logic [2:0]  d_mode,
  output logic        d_rsp_valid,
  output logic [31:0] d_rsp_rdata,
  output logic        d_rsp_err,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_we,
  output logic [2:0]  mem_mode,
  input  logic [31:0] mem_rdata
);

  dm_req_t          c_req, d_req, sel_req;
  logic             c_legal, d_legal, sel_legal;
  grant_e           grant;
  logic [CNT_W-1:0] starve_q, starve_d;

  logic        c_rsp_valid_q, c_rsp_valid_d;
  logic        c_rsp_err_q, c_rsp_err_d;
  logic [31:0] c_rsp_rdata_q, c_rsp_rdata_d;
  logic        d_rsp_valid_q, d_rsp_valid_d;
  logic        d_rsp_err_q, d_rsp_err_d;
  logic [31:0] d_rsp_rdata_q, d_rsp_rdata_d;

  assign c_req = {c_addr, c_wdata, c_we, c_mode};
  assign d_req = {d_addr, d_wdata, d_we, d_mode};

  dmem_access_check #(
    .MemBytes(MEM_BYTES)
  ) u_c_check (
    .addr_i (c_addr),
    .mode_i (c_mode),
    .legal_o(c_legal)
  );

  dmem_access_check #(
    .MemBytes(MEM_BYTES)
  ) u_d_check (
    .addr_i (d_addr),
    .mode_i (d_mode),
    .legal_o(d_legal)
  );

  // No grants while in reset so an accept cannot write or produce a response.
  always_comb begin
    grant = GntNone;
    if (!rst) begin
      if (d_valid && (!c_valid || starve_q == CNT_W'(STARVE_LIMIT))) begin
        grant = GntD;
      end else if (c_valid) begin
        grant = GntC;
      end
    end
  end

  assign c_ready = (grant == GntC);
  assign d_ready = (grant == GntD);

  always_comb begin
    sel_req   = '{addr: '0, wdata: '0, we: 1'b0, mode: DM_LW};
    sel_legal = 1'b0;
    case (grant)
      GntC: begin
        sel_req   = c_req;
        sel_legal = c_legal;
      end
      GntD: begin
        sel_req   = d_req;
        sel_legal = d_legal;
      end
      default: ;
    endcase
    mem_addr  = sel_req.addr;
    mem_wdata = sel_req.wdata;
    mem_mode  = sel_req.mode;
    mem_we    = sel_req.we && sel_legal;
  end

  always_comb begin
    starve_d = starve_q;
    if (!d_valid || grant == GntD) begin
      starve_d = '0;
    end else if (starve_q != CNT_W'(STARVE_LIMIT)) begin
      starve_d = starve_q + CNT_W'(1);
    end
  end

  always_comb begin
    c_rsp_valid_d = (grant == GntC);
    c_rsp_err_d   = (grant == GntC) && !c_legal;
    c_rsp_rdata_d = (grant == GntC && c_legal && !c_we) ? mem_rdata : '0;
    d_rsp_valid_d = (grant == GntD);
    d_rsp_err_d   = (grant == GntD) && !d_legal;
    d_rsp_rdata_d = (grant == GntD && d_legal && !d_we) ? mem_rdata : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      starve_q      <= '0;
      c_rsp_valid_q <= 1'b0;
      c_rsp_err_q   <= 1'b0;
      c_rsp_rdata_q <= '0;
      d_rsp_valid_q <= 1'b0;
      d_rsp_err_q   <= 1'b0;
      d_rsp_rdata_q <= '0;
    end else begin
      starve_q      <= starve_d;
      c_rsp_valid_q <= c_rsp_valid_d;
      c_rsp_err_q   <= c_rsp_err_d;
      c_rsp_rdata_q <= c_rsp_rdata_d;
      d_rsp_valid_q <= d_rsp_valid_d;
      d_rsp_err_q   <= d_rsp_err_d;
      d_rsp_rdata_q <= d_rsp_rdata_d;
    end
  end

  assign c_rsp_valid = c_rsp_valid_q;
  assign c_rsp_err   = c_rsp_err_q;
  assign c_rsp_rdata = c_rsp_rdata_q;
  assign d_rsp_valid = d_rsp_valid_q;
  assign d_rsp_err   = d_rsp_err_q;
  assign d_rsp_rdata = d_rsp_rdata_q;

endmodule
